// File: rtl/stream_demux_1_to_2.sv
// Registered 1-to-2 stream demultiplexer: each accepted beat is steered by select_i
// into one of two independent 2-entry FIFO lanes, with per-lane acceptance counters.
module stream_demux_1_to_2 #(
   parameter int size = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [size-1:0] data_i,
   input  logic            select_i,
   input  logic            valid_i,
   output logic            ready_o,
   output logic [size-1:0] data0_o,
   output logic            valid0_o,
   input  logic            ready0_i,
   output logic [size-1:0] data1_o,
   output logic            valid1_o,
   input  logic            ready1_i,
   output logic [15:0]     cnt0_o,
   output logic [15:0]     cnt1_o
);

   // Per lane: entry 0 is the head, entry 1 sits behind it.
   logic [size-1:0] r_buf [2][2];
   logic [1:0]      r_occ [2];
   logic [15:0]     r_cnt [2];

   logic       w_ready;
   logic [1:0] w_push;
   logic [1:0] w_pop;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      w_ready = select_i ? (r_occ[1] != 2'd2) : (r_occ[0] != 2'd2);
      w_push  = 2'b00;
      w_push[0] = valid_i & w_ready & ~select_i;
      w_push[1] = valid_i & w_ready &  select_i;
      w_pop[0]  = (r_occ[0] != 2'd0) & ready0_i;
      w_pop[1]  = (r_occ[1] != 2'd0) & ready1_i;
   end

   // NOTE: state uses non-blocking assignments so every lane sees pre-edge values;
   // the buffer entries are reset too because their contents are visible on data_x_o.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int l = 0; l < 2; l++) begin
            r_occ[l]    <= 2'd0;
            r_cnt[l]    <= 16'd0;
            r_buf[l][0] <= '0;
            r_buf[l][1] <= '0;
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            case ({w_push[l], w_pop[l]})
               2'b10: begin
                  if (r_occ[l] == 2'd0) r_buf[l][0] <= data_i;
                  else                  r_buf[l][1] <= data_i;
                  r_occ[l] <= r_occ[l] + 2'd1;
               end
               2'b01: begin
                  r_buf[l][0] <= r_buf[l][1];
                  r_buf[l][1] <= '0;
                  r_occ[l]    <= r_occ[l] - 2'd1;
               end
               2'b11: begin
                  // Head leaves; the new beat lands behind whatever remains.
                  if (r_occ[l] == 2'd1) begin
                     r_buf[l][0] <= data_i;
                  end else begin
                     r_buf[l][0] <= r_buf[l][1];
                     r_buf[l][1] <= data_i;
                  end
               end
               default: ;
            endcase
            if (w_push[l]) r_cnt[l] <= r_cnt[l] + 16'd1;
         end
      end
   end

   assign ready_o  = w_ready;
   assign data0_o  = r_buf[0][0];
   assign data1_o  = r_buf[1][0];
   assign valid0_o = (r_occ[0] != 2'd0);
   assign valid1_o = (r_occ[1] != 2'd0);
   assign cnt0_o   = r_cnt[0];
   assign cnt1_o   = r_cnt[1];

endmodule

// File: tb/tb_stream_demux_1_to_2.sv
// Self-checking bench for stream_demux_1_to_2: table-driven per-cycle vectors plus
// hand-written sequences for asynchronous reset and counter wrap.
module tb_stream_demux_1_to_2;

   localparam int W = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [W-1:0]  data_i;
   logic          select_i;
   logic          valid_i;
   logic          ready_o;
   logic [W-1:0]  data0_o;
   logic          valid0_o;
   logic          ready0_i;
   logic [W-1:0]  data1_o;
   logic          valid1_o;
   logic          ready1_i;
   logic [15:0]   cnt0_o;
   logic [15:0]   cnt1_o;

   int n_tests = 0;
   int n_fail  = 0;

   stream_demux_1_to_2 #(.size(W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .data0_o(data0_o), .valid0_o(valid0_o), .ready0_i(ready0_i),
      .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(ready1_i),
      .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          valid;
      logic          sel;
      logic [W-1:0]  data;
      logic          rdy0;
      logic          rdy1;
      logic          exp_ready;
      logic          exp_v0;
      logic [W-1:0]  exp_d0;
      logic          exp_v1;
      logic [W-1:0]  exp_d1;
      logic [15:0]   exp_c0;
      logic [15:0]   exp_c1;
   } vec_t;

   vec_t vecs [22];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      // valid sel data rdy0 rdy1 | ready v0 d0 v1 d1 c0 c1 (expected after the edge, ready before it)
      vecs[0]  = '{1, 0, 32'hA5A5A5A5, 1, 1, 1, 1, 32'hA5A5A5A5, 0, 0, 1, 0};
      vecs[1]  = '{0, 0, 32'h0,  1, 1, 1, 0, 32'h0,  0, 32'h0,  1, 0};
      vecs[2]  = '{1, 1, 32'h11, 1, 0, 1, 0, 32'h0,  1, 32'h11, 1, 1};
      vecs[3]  = '{1, 1, 32'h22, 1, 0, 1, 0, 32'h0,  1, 32'h11, 1, 2};
      vecs[4]  = '{1, 1, 32'h99, 1, 0, 0, 0, 32'h0,  1, 32'h11, 1, 2};
      vecs[5]  = '{1, 0, 32'h33, 0, 0, 1, 1, 32'h33, 1, 32'h11, 2, 2};
      vecs[6]  = '{0, 1, 32'h0,  1, 1, 0, 0, 32'h0,  1, 32'h22, 2, 2};
      vecs[7]  = '{0, 1, 32'h0,  1, 1, 1, 0, 32'h0,  0, 32'h0,  2, 2};
      vecs[8]  = '{1, 0, 32'h1,  1, 1, 1, 1, 32'h1,  0, 32'h0,  3, 2};
      vecs[9]  = '{1, 1, 32'h2,  1, 1, 1, 0, 32'h0,  1, 32'h2,  3, 3};
      vecs[10] = '{1, 0, 32'h3,  1, 1, 1, 1, 32'h3,  0, 32'h0,  4, 3};
      vecs[11] = '{1, 1, 32'h4,  1, 1, 1, 0, 32'h0,  1, 32'h4,  4, 4};
      vecs[12] = '{0, 0, 32'h0,  1, 1, 1, 0, 32'h0,  0, 32'h0,  4, 4};
      vecs[13] = '{1, 0, 32'h5,  1, 1, 1, 1, 32'h5,  0, 32'h0,  5, 4};
      vecs[14] = '{1, 0, 32'h55, 1, 1, 1, 1, 32'h55, 0, 32'h0,  6, 4};
      vecs[15] = '{0, 0, 32'h0,  1, 1, 1, 0, 32'h0,  0, 32'h0,  6, 4};
      vecs[16] = '{1, 0, 32'hA0, 0, 1, 1, 1, 32'hA0, 0, 32'h0,  7, 4};
      vecs[17] = '{1, 0, 32'hB0, 0, 1, 1, 1, 32'hA0, 0, 32'h0,  8, 4};
      vecs[18] = '{1, 0, 32'hC0, 0, 1, 0, 1, 32'hA0, 0, 32'h0,  8, 4};
      vecs[19] = '{0, 0, 32'h0,  1, 1, 0, 1, 32'hB0, 0, 32'h0,  8, 4};
      vecs[20] = '{1, 0, 32'hD0, 1, 1, 1, 1, 32'hD0, 0, 32'h0,  9, 4};
      vecs[21] = '{0, 0, 32'h0,  1, 1, 1, 0, 32'h0,  0, 32'h0,  9, 4};

      rst_i = 1'b0; data_i = '0; select_i = 1'b0; valid_i = 1'b0;
      ready0_i = 1'b0; ready1_i = 1'b0;
      #12;
      check("reset ready_o",  ready_o,  1);
      check("reset valid0_o", valid0_o, 0);
      check("reset valid1_o", valid1_o, 0);
      check("reset data0_o",  data0_o,  0);
      check("reset data1_o",  data1_o,  0);
      check("reset cnt0_o",   cnt0_o,   0);
      check("reset cnt1_o",   cnt1_o,   0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < 22; i++) begin
         valid_i  = vecs[i].valid;
         select_i = vecs[i].sel;
         data_i   = vecs[i].data;
         ready0_i = vecs[i].rdy0;
         ready1_i = vecs[i].rdy1;
         #1;
         check($sformatf("vec%0d ready_o", i), ready_o, vecs[i].exp_ready);
         @(posedge clk_i); #1;
         check($sformatf("vec%0d valid0_o", i), valid0_o, vecs[i].exp_v0);
         check($sformatf("vec%0d valid1_o", i), valid1_o, vecs[i].exp_v1);
         if (vecs[i].exp_v0) check($sformatf("vec%0d data0_o", i), data0_o, vecs[i].exp_d0);
         if (vecs[i].exp_v1) check($sformatf("vec%0d data1_o", i), data1_o, vecs[i].exp_d1);
         check($sformatf("vec%0d cnt0_o", i), cnt0_o, vecs[i].exp_c0);
         check($sformatf("vec%0d cnt1_o", i), cnt1_o, vecs[i].exp_c1);
      end

      // Fill lane 0 while its consumer stalls, then reset asynchronously mid-cycle.
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'hE1; ready0_i = 1'b0; ready1_i = 1'b1;
      @(posedge clk_i); #1;
      data_i = 32'hE2;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("full ready_o", ready_o, 0);
      check("full data0_o", data0_o, 32'hE1);
      #3;
      rst_i = 1'b0;
      #1;
      check("async rst valid0_o", valid0_o, 0);
      check("async rst cnt0_o",   cnt0_o,   0);
      check("async rst data0_o",  data0_o,  0);
      check("async rst ready_o",  ready_o,  1);
      #2;
      rst_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b1; select_i = 1'b0; data_i = 32'h77;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("post rst valid0_o", valid0_o, 1);
      check("post rst data0_o",  data0_o,  32'h77);
      check("post rst cnt0_o",   cnt0_o,   1);
      check("post rst cnt1_o",   cnt1_o,   0);

      // Counter wrap on lane 1 with its consumer always ready.
      valid_i = 1'b1; select_i = 1'b1; ready1_i = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         data_i = i;
         @(posedge clk_i); #1;
      end
      check("wrap cnt1 at ffff", cnt1_o, 16'hFFFF);
      check("wrap lane1 head",   data1_o, 32'd65534);
      data_i = 32'hFFFF;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("wrap cnt1 to 0",  cnt1_o, 16'h0000);
      check("wrap cnt0 held",  cnt0_o, 1);
      @(posedge clk_i); #1;
      check("wrap drain valid1_o", valid1_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
